// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS front end and controller.
//
// Contents:
//   state_t          - fetch-stage state encoding (FETCH, VALID, plus RETRY
//                      when IFETCH_TIMEOUT_EN is defined)
//   OP_*             - primary opcode constants shared with the controller
//   RESET_PC_DEFAULT - default PC loaded on reset
//
// Configuration macro: IFETCH_TIMEOUT_EN adds the RETRY state used by the
// fetch timeout logic.
package mips_pkg;

`ifdef IFETCH_TIMEOUT_EN
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    RETRY = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    FETCH = 1'b0,
    VALID = 1'b1
  } state_t;
`endif

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection for the fetch stage, purely combinational so that later
// pipelined variants can reuse it unchanged.
//
// Ports:
//   pc_plus4 - address of the sequentially following instruction
//   instr    - low 26 bits of the current instruction (jump target and
//              branch immediate fields; the opcode is not needed here)
//   branch   - controller branch output
//   zero     - ALU zero flag
//   jump     - controller jump output
//   npc      - selected next PC (jump beats a taken branch beats pc_plus4)
module pc_next_sel (
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] npc
);

  logic [31:0] jumpTarget;
  logic [31:0] branchOffset;

  // Jump stays inside the 256 MB region of the following instruction; the
  // branch immediate is a signed word offset, so sign-extend and scale by 4.
  assign jumpTarget   = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign branchOffset = {{14{instr[15]}}, instr[15:0], 2'b00};

  // Priority select; additions wrap modulo 2^32 by construction.
  always_comb begin
    npc = pc_plus4;
    if (jump) begin
      npc = jumpTarget;
    end else if (branch && zero) begin
      npc = pc_plus4 + branchOffset;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage feeding the single-cycle controller. Owns the PC,
// requests words from instruction memory over a req/ack handshake, holds the
// returned word in the instruction register until the downstream stage
// consumes it, then advances the PC from the branch/jump/zero inputs.
//
// Parameters:
//   RESET_PC       - PC value loaded on reset
//   TIMEOUT_CYCLES - FETCH wait limit before a re-request (timeout build only)
//
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   imem_req/imem_addr    - fetch request and byte address (always pc)
//   imem_ack/imem_rdata   - memory response, rdata valid while ack is high
//   instr, op, funct      - registered instruction and its opcode/funct fields
//   instr_valid           - instr holds an unconsumed instruction
//   instr_ready           - downstream consumes instr this cycle
//   branch, zero, jump    - next-PC controls, sampled on the consuming edge
//   pc, pc_plus4          - current instruction address and its successor
//   fetch_err             - sticky timeout flag
//
// Configuration macro: IFETCH_TIMEOUT_EN enables the FETCH wait counter, the
// one-cycle request drop (RETRY state) and the sticky fetch_err flag. Without
// it, fetch_err is tied low and FETCH waits for an ack indefinitely.
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc;

`ifdef IFETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wait_q, wait_d;
  logic          err_q, err_d;
`endif

  pc_next_sel u_pc_next_sel (
    .pc_plus4 (pc_plus4),
    .instr    (instr_q[25:0]),
    .branch   (branch),
    .zero     (zero),
    .jump     (jump),
    .npc      (npc)
  );

  // Next-state logic. The ack is only looked at in FETCH, so a spurious ack
  // while VALID (or RETRY) leaves the instruction register untouched.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef IFETCH_TIMEOUT_EN
    wait_d  = wait_q;
    err_d   = err_q;
`endif
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = VALID;
`ifdef IFETCH_TIMEOUT_EN
          wait_d  = '0;
        end else if (wait_q == WAIT_LIMIT) begin
          // Give up on this request: flag it, drop req for one cycle, retry.
          wait_d  = '0;
          err_d   = 1'b1;
          state_d = RETRY;
        end else begin
          wait_d  = wait_q + 1'b1;
`endif
        end
      end
      VALID: begin
        if (instr_ready) begin
          pc_d    = npc;
          state_d = FETCH;
        end
      end
`ifdef IFETCH_TIMEOUT_EN
      RETRY: begin
        state_d = FETCH;
      end
`endif
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State registers with synchronous reset; reset wins over any ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
`ifdef IFETCH_TIMEOUT_EN
      wait_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef IFETCH_TIMEOUT_EN
      wait_q  <= wait_d;
      err_q   <= err_d;
`endif
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign instr_valid = (state_q == VALID);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign funct       = instr_q[5:0];

`ifdef IFETCH_TIMEOUT_EN
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit. A driver plays the instruction memory
// and the downstream controller; every delivered word and every PC update is
// predicted by a reference model built directly from the fetch rules. A
// monitor pops predicted instructions when the DUT presents one and checks
// the request address against the model PC whenever a request is raised.
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch;
  logic        zero;
  logic        jump;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        expQ[$];
  exp_t        cur;
  logic [31:0] modelPc;
  logic        expErr;
  logic        prevValid;
  int          tests = 0;
  int          fails = 0;

  ifetch_unit #(
    .RESET_PC       (RESET_PC),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .op          (op),
    .funct       (funct),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference next-PC rule written as plain address arithmetic.
  function automatic logic [31:0] refNextPc(input logic [31:0] curPc, input logic [31:0] word,
                                            input bit br, input bit z, input bit j);
    logic [31:0] seq;
    logic [31:0] imm;
    seq = curPc + 32'd4;
    imm = {{16{word[15]}}, word[15:0]};
    if (j) return {seq[31:28], word[25:0], 2'b00};
    if (br && z) return seq + imm * 32'd4;
    return seq;
  endfunction

  // Memory side: idle for a few FETCH cycles, then return the word.
  task automatic applyStimulus(input logic [31:0] word, input int idle);
    imem_ack = 1'b0;
    repeat (idle) @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = word;
    expQ.push_back('{pc: modelPc, word: word});
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
  endtask

  // Controller side: optionally stall (with noise on the ignored inputs),
  // then consume the instruction and advance the model PC.
  task automatic consumeInstr(input bit br, input bit z, input bit j, input int stall);
    repeat (stall) begin
      instr_ready = 1'b0;
      imem_ack    = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      {branch, zero, jump} = 3'($urandom);
      @(negedge clk);
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    branch      = br;
    zero        = z;
    jump        = j;
    modelPc     = refNextPc(modelPc, cur.word, br, z, j);
    @(negedge clk);
    instr_ready = 1'b0;
    {branch, zero, jump} = 3'($urandom);
  endtask

  task automatic fetchExec(input logic [31:0] word, input bit br, input bit z, input bit j);
    applyStimulus(word, 0);
    consumeInstr(br, z, j, 0);
  endtask

  task automatic doReset(input int cycles, input bit ackDuring);
    rst      = 1'b1;
    imem_ack = ackDuring;
    imem_rdata = $urandom;
    expErr   = 1'b0;
    expQ.delete();
    modelPc  = RESET_PC;
    repeat (cycles) @(negedge clk);
    rst      = 1'b0;
    imem_ack = 1'b0;
    checkOutput("rst_req", 32'(imem_req), 32'd1);
    checkOutput("rst_addr", imem_addr, RESET_PC);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_instr", instr, 32'd0);
    checkOutput("rst_err", 32'(fetch_err), 32'd0);
  endtask

  // Monitor: samples well after each rising edge.
  initial begin
    prevValid = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        prevValid = 1'b0;
      end else begin
        if (instr_valid) begin
          if (!prevValid) begin
            if (expQ.size() == 0) begin
              checkOutput("sb_unexpected_valid", 32'd1, 32'd0);
            end else begin
              cur = expQ.pop_front();
            end
          end
          checkOutput("sb_instr", instr, cur.word);
          checkOutput("sb_op", 32'(op), 32'(cur.word[31:26]));
          checkOutput("sb_funct", 32'(funct), 32'(cur.word[5:0]));
          checkOutput("sb_pc", pc, cur.pc);
          checkOutput("sb_pc_plus4", pc_plus4, cur.pc + 32'd4);
          checkOutput("sb_req_in_valid", 32'(imem_req), 32'd0);
        end
        if (imem_req) begin
          checkOutput("sb_fetch_addr", imem_addr, modelPc);
        end
        checkOutput("sb_fetch_err", 32'(fetch_err), 32'(expErr));
        prevValid = instr_valid;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
    expErr = 1'b0; modelPc = RESET_PC;
    cur = '{pc: '0, word: '0};
    @(negedge clk);
    doReset(2, 1'b0);

    // Sequential fetch of an addi.
    applyStimulus(32'h2008_0005, 0);
    checkOutput("seq_valid", 32'(instr_valid), 32'd1);
    checkOutput("seq_op", 32'(op), 32'h08);
    checkOutput("seq_funct", 32'(funct), 32'h05);
    consumeInstr(1'b0, 1'b0, 1'b0, 0);
    checkOutput("seq_addr", imem_addr, 32'h4);
    checkOutput("seq_req", 32'(imem_req), 32'd1);

    // Walk to 0x10, then beq with offset -1 taken and not taken.
    repeat (3) fetchExec(32'h0000_0020, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_branch_addr", imem_addr, 32'h10);
    fetchExec(32'h1000_FFFF, 1'b1, 1'b1, 1'b0);
    checkOutput("beq_taken", imem_addr, 32'h10);
    fetchExec(32'h1000_FFFF, 1'b1, 1'b0, 1'b0);
    checkOutput("beq_not_taken", imem_addr, 32'h14);

    // Climb region by region with jumps to reach 0x4000_0008.
    repeat (3) begin
      fetchExec(32'h0BFF_FFFF, 1'b0, 1'b0, 1'b1);
      fetchExec(32'h0000_0020, 1'b0, 1'b0, 1'b0);
    end
    fetchExec(32'h0BFF_FFFF, 1'b0, 1'b0, 1'b1);
    checkOutput("jump_region_top", imem_addr, 32'h3FFF_FFFC);
    repeat (3) fetchExec(32'h0000_0020, 1'b0, 1'b0, 1'b0);
    checkOutput("jump_pre_addr", imem_addr, 32'h4000_0008);
    fetchExec(32'h0800_0010, 1'b1, 1'b1, 1'b1);
    checkOutput("jump_wins", imem_addr, 32'h4000_0040);

    // Stall with a spurious ack, then consume.
    applyStimulus(32'h8C43_0004, 1);
    for (int i = 0; i < 5; i++) begin
      instr_ready = 1'b0;
      imem_ack    = (i == 2);
      imem_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      checkOutput("stall_instr", instr, 32'h8C43_0004);
      checkOutput("stall_pc", pc, 32'h4000_0040);
      checkOutput("stall_valid", 32'(instr_valid), 32'd1);
    end
    imem_ack = 1'b0;
    consumeInstr(1'b0, 1'b0, 1'b0, 0);

    // Reset in FETCH while memory acks: the ack must be dropped.
    doReset(1, 1'b1);

    // Backward branch from 0 wraps to the top of memory and back to 0.
    fetchExec(32'h1000_FFFE, 1'b1, 1'b1, 1'b0);
    checkOutput("wrap_down", imem_addr, 32'hFFFF_FFFC);
    fetchExec(32'h0000_0020, 1'b0, 1'b0, 1'b0);
    checkOutput("wrap_up", imem_addr, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] w;
      bit br, z, j;
      w  = $urandom;
      br = ($urandom_range(0, 2) == 0);
      z  = 1'($urandom_range(0, 1));
      j  = ($urandom_range(0, 4) == 0);
      applyStimulus(w, $urandom_range(0, 2));
      consumeInstr(br, z, j, $urandom_range(0, 3));
    end

`ifdef IFETCH_TIMEOUT_EN
    // Four unacknowledged FETCH cycles, one dropped request, same address.
    for (int i = 0; i < 3; i++) begin
      checkOutput("to_req_wait", 32'(imem_req), 32'd1);
      @(negedge clk);
    end
    checkOutput("to_req_last", 32'(imem_req), 32'd1);
    expErr = 1'b1;
    @(negedge clk);
    checkOutput("to_req_drop", 32'(imem_req), 32'd0);
    checkOutput("to_err_set", 32'(fetch_err), 32'd1);
    @(negedge clk);
    checkOutput("to_rereq", 32'(imem_req), 32'd1);
    checkOutput("to_rereq_addr", imem_addr, modelPc);
    fetchExec($urandom, 1'b0, 1'b0, 1'b0);
    checkOutput("to_err_sticky", 32'(fetch_err), 32'd1);
`else
    // Without the timeout, FETCH waits indefinitely with no error.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("wait_req", 32'(imem_req), 32'd1);
    end
    fetchExec($urandom, 1'b0, 1'b0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage directly upstream of the single-cycle controller. Owns the PC and issues requests to instruction memory over a req/ack handshake.
- Latches the returned word into an instruction register (IR) and presents IR[31:26]/IR[5:0] as op/funct to the controller.
- Once the instruction is consumed, computes the next PC from the controller's branch/jump outputs and the ALU zero flag.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT_CYCLES, 16, wait-cycle limit before re-request (only with IFETCH_TIMEOUT_EN)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  fetch request, held high until acknowledged
imem_addr  output  32  byte address of the requested word, always equal to pc
imem_ack  input  1  imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
instr  output  32  instruction register contents
op  output  6  instr[31:26], to the controller
funct  output  6  instr[5:0], to the controller
instr_valid  output  1  instr holds an unconsumed instruction
instr_ready  input  1  downstream executes/consumes instr this cycle
branch  input  1  controller branch output for the current instr
zero  input  1  ALU zero flag for the current instr
jump  input  1  controller jump output for the current instr
pc  output  32  address of the current instruction
pc_plus4  output  32  pc + 4, for link/branch datapath use
fetch_err  output  1  sticky timeout flag (constant 0 without the macro)

Behaviour:
- Reset (rst=1 at a clock edge, any state, including mid-request): pc<=RESET_PC, instr<=0, state<=FETCH, fetch_err<=0. An imem_ack in the reset cycle is ignored.
- State FETCH: imem_req=1, instr_valid=0.
  - On an edge with imem_ack=1: instr<=imem_rdata, state<=VALID.
  - imem_ack may arrive in the first FETCH cycle, giving a minimum 1-cycle fetch latency.
- State VALID: imem_req=0, instr_valid=1.
  - On an edge with instr_ready=1: pc<=npc, state<=FETCH.
  - Otherwise hold pc, instr and state.
  - imem_ack in VALID is ignored (spurious).
- npc selection, jump has priority over branch:
  - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}
  - else branch&zero: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00})
  - else: pc_plus4
  - All additions are modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- branch, jump and zero are sampled only on the consuming edge; their values in other cycles have no effect.
- op, funct and instr are purely registered, so they are stable for the whole VALID period.
- imem_addr and pc_plus4 are combinational from pc.
- A back-to-back throughput of 1 instruction per 2 cycles is acceptable and is the specified maximum.

Optional Feature:
- Macro IFETCH_TIMEOUT_EN.
- Defined:
  - A wait counter increments each FETCH cycle without imem_ack.
  - When it reaches TIMEOUT_CYCLES-1 without an ack: fetch_err<=1 (sticky until rst), the counter clears, and imem_req drops low for exactly one cycle before re-asserting with the same address.
  - The counter clears on ack and on rst.
- Undefined: no counter logic, fetch_err tied to 0, and FETCH waits indefinitely.

Decomposition:
- Shared package mips_pkg:
  - state encoding (FETCH, VALID, and RETRY when IFETCH_TIMEOUT_EN is defined)
  - opcode constants OP_RTYPE=6'h00, OP_J=6'h02, OP_BEQ=6'h04, OP_ADDI=6'h08, OP_LW=6'h23, OP_SW=6'h2B, shared with the controller
  - default RESET_PC
- One sub-module, pc_next_sel: purely combinational npc computation (inputs pc_plus4, instr, branch, zero, jump; output npc). It is reused by later pipelined variants.

Test Plan:
- Reset:
  - rst high 2 cycles, then low → imem_req=1, imem_addr=0, instr_valid=0, fetch_err=0.
- Sequential fetch:
  - ack with rdata=32'h2008_0005 → next cycle instr_valid=1, op=6'h08, funct=6'h05.
  - instr_ready=1, branch=jump=0 → imem_addr=4, imem_req=1.
- Branch taken/not taken at pc=32'h10, instr=32'h1000_FFFF (beq, imm -1):
  - branch=1, zero=1 on consume → next imem_addr=32'h10.
  - Same with zero=0 → 32'h14.
- Jump:
  - pc=32'h4000_0008, instr=32'h0800_0010, jump=1 and branch=1 → next imem_addr=32'h4000_0040 (jump wins).
- Stall and mid-operation reset:
  - instr_ready=0 for 5 cycles → instr, pc, instr_valid unchanged, and a spurious imem_ack is ignored.
  - Then rst during FETCH with imem_ack=1 → pc=RESET_PC, instr=0, state FETCH.
- Timeout (IFETCH_TIMEOUT_EN defined, TIMEOUT_CYCLES=4):
  - No ack → fetch_err=1 after 4 FETCH cycles, imem_req low 1 cycle, then re-request at the same address.
  - A later ack proceeds normally with fetch_err still 1.
